// File: rtl/tetris_board_pkg.sv
// rtl/tetris_board_pkg.sv - board geometry, cell/row types and arbiter enums
package tetris_board_pkg;
   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam int CELL_W  = 16;

   typedef logic [CELL_W-1:0] cell_t;
   typedef cell_t [BOARD_W-1:0] row_t;

   typedef enum logic [1:0] {IDLE, BURST, DRAIN, COMMIT} arb_state_t;
   typedef enum logic {TAG_VID, TAG_GAME} rd_tag_t;
endpackage

// File: rtl/board_addr_gen.sv
// rtl/board_addr_gen.sv - maps (row, col) to a linear RAM address with range check
module board_addr_gen
   import tetris_board_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic [7:0]        row,
   input  logic [3:0]        col,
   output logic [ADDR_W-1:0] addr,
   output logic              in_range
);
   always_comb begin
      in_range = (row < 8'(BOARD_H)) && (col < 4'(BOARD_W));
      // Out-of-range cells present address 0 so nothing stray reaches the RAM pins
      addr = in_range ? (ADDR_W'(row) * ADDR_W'(BOARD_W) + ADDR_W'(col)) : '0;
   end
endmodule

// File: rtl/board_mem_arbiter.sv
// rtl/board_mem_arbiter.sv - board RAM arbiter: video row bursts over game cell accesses
// Optional statistics outputs enabled by BOARD_ARB_STATS_EN.
module board_mem_arbiter
   import tetris_board_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              Clk,
   input  logic              reset_n,
   input  logic              vid_ld,
   input  logic [7:0]        vid_row,
   output row_t              row_out,
   output logic              row_ready,
   input  logic              game_req,
   input  logic              game_we,
   input  logic [7:0]        game_row,
   input  logic [3:0]        game_col,
   input  cell_t             game_wdata,
   output logic              game_gnt,
   output logic              game_rvalid,
   output cell_t             game_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output cell_t             mem_wdata,
   input  cell_t             mem_rdata
`ifdef BOARD_ARB_STATS_EN
   ,
   output logic [7:0]        overrun_cnt,
   output logic [7:0]        defer_cnt
`endif
);
   arb_state_t        state, state_nxt;
   logic [3:0]        col_q;
   logic [7:0]        vrow_q;
   row_t              shadow;

   logic              rd_vld_q;
   rd_tag_t           rd_tag_q;
   logic [3:0]        rd_col_q;
   logic              rd_oor_q;

   logic              rd_issue;
   rd_tag_t           rd_issue_tag;
   logic              commit;

   logic [7:0]        ag_row;
   logic [3:0]        ag_col;
   logic [ADDR_W-1:0] ag_addr;
   logic              ag_in_range;

   // One address generator serves both requesters; the burst owns it while active
   assign ag_row = (state == BURST) ? vrow_q : game_row;
   assign ag_col = (state == BURST) ? col_q  : game_col;

   board_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .row      (ag_row),
      .col      (ag_col),
      .addr     (ag_addr),
      .in_range (ag_in_range)
   );

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      mem_addr     = '0;
      mem_we       = 1'b0;
      mem_wdata    = '0;
      game_gnt     = 1'b0;
      rd_issue     = 1'b0;
      rd_issue_tag = TAG_GAME;
      commit       = 1'b0;
      case (state)
         IDLE: begin
            if (vid_ld) begin
               state_nxt = BURST;
            end else if (game_req) begin
               game_gnt  = 1'b1;
               mem_addr  = ag_addr;
               mem_we    = game_we & ag_in_range;
               mem_wdata = (game_we & ag_in_range) ? game_wdata : '0;
               rd_issue  = ~game_we;
            end
         end
         BURST: begin
            mem_addr     = ag_addr;
            rd_issue     = 1'b1;
            rd_issue_tag = TAG_VID;
            if (col_q == 4'(BOARD_W - 1)) state_nxt = DRAIN;
         end
         DRAIN:   state_nxt = COMMIT;
         COMMIT: begin
            commit    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Rows past the bottom of the board wrap to row 0 at end of frame
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q  <= '0;
         vrow_q <= '0;
      end else if (state == IDLE && vid_ld) begin
         col_q  <= '0;
         vrow_q <= (vid_row < 8'(BOARD_H)) ? vid_row : 8'd0;
      end else if (state == BURST) begin
         col_q  <= col_q + 4'd1;
      end
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_vld_q <= 1'b0;
         rd_tag_q <= TAG_VID;
         rd_col_q <= '0;
         rd_oor_q <= 1'b0;
      end else begin
         rd_vld_q <= rd_issue;
         rd_tag_q <= rd_issue_tag;
         rd_col_q <= col_q;
         rd_oor_q <= ~ag_in_range;
      end
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow    <= '0;
         row_out   <= '0;
         row_ready <= 1'b0;
      end else begin
         if (rd_vld_q && rd_tag_q == TAG_VID) shadow[rd_col_q] <= mem_rdata;
         if (commit) row_out <= shadow;
         row_ready <= commit;
      end
   end

   assign game_rvalid = rd_vld_q && (rd_tag_q == TAG_GAME);
   assign game_rdata  = (game_rvalid && !rd_oor_q) ? mem_rdata : '0;

`ifdef BOARD_ARB_STATS_EN
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_cnt <= '0;
         defer_cnt   <= '0;
      end else begin
         if (vid_ld && state != IDLE && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
         if (game_req && !game_gnt && defer_cnt != 8'hFF)
            defer_cnt <= defer_cnt + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb/tb_board_mem_arbiter.sv - self-checking bench for board_mem_arbiter
module tb_board_mem_arbiter;
   import tetris_board_pkg::*;

   logic        Clk = 1'b0;
   logic        reset_n;
   logic        vid_ld;
   logic [7:0]  vid_row;
   row_t        row_out;
   logic        row_ready;
   logic        game_req;
   logic        game_we;
   logic [7:0]  game_row;
   logic [3:0]  game_col;
   logic [15:0] game_wdata;
   logic        game_gnt;
   logic        game_rvalid;
   logic [15:0] game_rdata;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
`ifdef BOARD_ARB_STATS_EN
   logic [7:0]  overrun_cnt;
   logic [7:0]  defer_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] ram [0:255];
   logic [15:0] model [0:BOARD_H-1][0:BOARD_W-1];

   board_mem_arbiter #(.ADDR_W(8)) dut (
      .Clk         (Clk),
      .reset_n     (reset_n),
      .vid_ld      (vid_ld),
      .vid_row     (vid_row),
      .row_out     (row_out),
      .row_ready   (row_ready),
      .game_req    (game_req),
      .game_we     (game_we),
      .game_row    (game_row),
      .game_col    (game_col),
      .game_wdata  (game_wdata),
      .game_gnt    (game_gnt),
      .game_rvalid (game_rvalid),
      .game_rdata  (game_rdata),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
`ifdef BOARD_ARB_STATS_EN
      ,
      .overrun_cnt (overrun_cnt),
      .defer_cnt   (defer_cnt)
`endif
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [15:0] ref_cell(input int row, input int col);
      if (row >= BOARD_H || col >= BOARD_W) return 16'h0000;
      return model[row][col];
   endfunction

   // Call in cycle t+1 (vid_ld sampled at edge t); checks commit timing and contents
   task automatic wait_commit(input int row, input bit overrun);
      int er;
      er = (row >= BOARD_H) ? 0 : row;
      for (int i = 1; i <= 16; i++) begin
         if (overrun) vid_ld = (i == 5);
         #1;
         chk($sformatf("row_ready@t+%0d", i), row_ready, (i == 13));
         if (i == 13)
            for (int k = 0; k < BOARD_W; k++)
               chk($sformatf("row_out[%0d] row %0d", k, er), row_out[k], ref_cell(er, k));
         tick();
      end
      vid_ld = 1'b0;
   endtask

   task automatic fetch(input int row, input bit overrun);
      vid_ld  = 1'b1;
      vid_row = row[7:0];
      tick();
      vid_ld  = 1'b0;
      wait_commit(row, overrun);
   endtask

   task automatic game_op(input bit we, input int row, input int col, input logic [15:0] wd);
      bit inr;
      inr        = (row < BOARD_H) && (col < BOARD_W);
      game_req   = 1'b1;
      game_we    = we;
      game_row   = row[7:0];
      game_col   = col[3:0];
      game_wdata = wd;
      #1;
      chk("game_gnt", game_gnt, 1);
      chk("mem_we", mem_we, we && inr);
      chk("mem_addr", mem_addr, inr ? (row * BOARD_W + col) : 0);
      if (we && inr) chk("mem_wdata", mem_wdata, wd);
      tick();
      game_req = 1'b0;
      #1;
      chk("game_rvalid", game_rvalid, !we);
      if (!we) chk($sformatf("game_rdata r%0d c%0d", row, col), game_rdata, ref_cell(row, col));
      if (we && inr) model[row][col] = wd;
      tick();
   endtask

   initial begin
      for (int r = 0; r < BOARD_H; r++)
         for (int c = 0; c < BOARD_W; c++)
            model[r][c] = 16'(16'h0100 * r + c);
      for (int a = 0; a < 256; a++)
         ram[a] = (a < BOARD_W * BOARD_H) ? 16'(16'h0100 * (a / BOARD_W) + (a % BOARD_W)) : 16'h0;

      reset_n = 1'b0; vid_ld = 1'b0; vid_row = '0;
      game_req = 1'b0; game_we = 1'b0; game_row = '0; game_col = '0; game_wdata = '0;
      repeat (3) tick();
      chk("rst row_ready", row_ready, 0);
      chk("rst game_gnt", game_gnt, 0);
      chk("rst game_rvalid", game_rvalid, 0);
      chk("rst mem_we", mem_we, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst game_rdata", game_rdata, 0);
      chk("rst row_out zero", (row_out == '0), 1);
      reset_n = 1'b1;
      tick();

      fetch(3, 0);
      fetch(20, 1);
`ifdef BOARD_ARB_STATS_EN
      chk("overrun_cnt", overrun_cnt, 1);
`endif

      // Video and a game write collide; game waits until the commit cycle
      game_req = 1'b1; game_we = 1'b1; game_row = 8'd3; game_col = 4'd4; game_wdata = 16'hABCD;
      vid_ld = 1'b1; vid_row = 8'd3;
      #1;
      chk("gnt deferred t", game_gnt, 0);
      tick();
      vid_ld = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         #1;
         if (game_req) chk($sformatf("gnt@t+%0d", i), game_gnt, (i == 13));
         chk($sformatf("coll row_ready@t+%0d", i), row_ready, (i == 13));
         if (i == 13) begin
            chk("old row_out[4]", row_out[4], 16'h0304);
            chk("coll mem_we", mem_we, 1);
            chk("coll mem_addr", mem_addr, 34);
         end
         tick();
         if (i == 13) game_req = 1'b0;
      end
      model[3][4] = 16'hABCD;
`ifdef BOARD_ARB_STATS_EN
      chk("defer_cnt", defer_cnt, 13);
`endif
      fetch(3, 0);

      // Game read granted the cycle before a burst starts
      game_req = 1'b1; game_we = 1'b0; game_row = 8'd5; game_col = 4'd9;
      #1;
      chk("pre-burst gnt", game_gnt, 1);
      chk("pre-burst addr", mem_addr, 59);
      tick();
      game_req = 1'b0; vid_ld = 1'b1; vid_row = 8'd5;
      #1;
      chk("pre-burst rvalid", game_rvalid, 1);
      chk("pre-burst rdata", game_rdata, 16'h0509);
      tick();
      vid_ld = 1'b0;
      wait_commit(5, 0);

      // Out-of-range game accesses: col 12 would alias into row 3 if not suppressed
      game_op(1, 2, 12, 16'hDEAD);
      game_op(0, 25, 3, 16'h0);
      fetch(3, 0);

      // Reset in burst cycle 4
      vid_ld = 1'b1; vid_row = 8'd7;
      tick();
      vid_ld = 1'b0;
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      chk("midrst row_out zero", (row_out == '0), 1);
      chk("midrst row_ready", row_ready, 0);
      chk("midrst mem_addr", mem_addr, 0);
      tick(); tick();
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("post-rst row_ready", row_ready, 0);
         chk("post-rst mem_addr", mem_addr, 0);
         tick();
      end
`ifdef BOARD_ARB_STATS_EN
      chk("post-rst overrun_cnt", overrun_cnt, 0);
`endif
      fetch(7, 0);

      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = $urandom_range(0, 2);
         if (kind == 0)
            fetch($urandom_range(0, 22), 0);
         else
            game_op(kind == 1, $urandom_range(0, 21), $urandom_range(0, 11), 16'($urandom));
      end
      for (int r = 0; r < BOARD_H; r++) fetch(r, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
